// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters between ID and WB,
// RAW/destination-full stall generation and WB-bypass forward selects.

typedef enum logic {
  rs1_s_id_id = 1'b0,
  rs1_s_wb_id = 1'b1
} rs1_forward_id_t;

typedef enum logic {
  rs2_s_id_id = 1'b0,
  rs2_s_wb_id = 1'b1
} rs2_forward_id_t;

module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd_s,
  input  logic [4:0]      id_rs1_s,
  input  logic [4:0]      id_rs2_s,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd_s,
  input  logic            squash_valid,
  input  logic [4:0]      squash_rd_s,
  output logic            id_stall,
  output rs1_forward_id_t rs1_forward_id,
  output rs2_forward_id_t rs2_forward_id,
  output logic [5:0]      inflight,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [CNT_W-1:0] eff   [32];
  logic [5:0]       inflight_q, inflight_d;
  logic             sb_err_q, sb_err_d;
  logic [31:0]      dec_wb, dec_sq, inc;
  logic             haz_1, haz_2, full, do_issue;

  always_comb begin
    logic [CNT_W+1:0] c_ext, n_ext, tot;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    dec_wb     = '0;
    dec_sq     = '0;
    inc        = '0;
    c_ext      = '0;
    n_ext      = '0;
    tot        = '0;
    sb_err_d   = sb_err_q;
    inflight_d = '0;
    for (int r = 0; r < 32; r++) begin
      eff[r]   = '0;
      cnt_d[r] = '0;
    end

    // x0 is never tracked: its decrements and its counter stay at zero.
    for (int r = 1; r < 32; r++) begin
      dec_wb[r] = wb_valid & wb_we & (wb_rd_s == 5'(r));
      dec_sq[r] = squash_valid & (squash_rd_s == 5'(r));
      c_ext     = (CNT_W+2)'(cnt_q[r]);
      n_ext     = (CNT_W+2)'(dec_wb[r]) + (CNT_W+2)'(dec_sq[r]);
      eff[r]    = (c_ext < n_ext) ? '0 : CNT_W'(c_ext - n_ext);
    end

    haz_1    = id_uses_rs1 & (id_rs1_s != 5'd0) & (eff[id_rs1_s] != '0);
    haz_2    = id_uses_rs2 & (id_rs2_s != 5'd0) & (eff[id_rs2_s] != '0);
    full     = issue_we & (issue_rd_s != 5'd0) & (eff[issue_rd_s] == CNT_MAX);
    id_stall = issue_valid & (haz_1 | haz_2 | full);
    do_issue = issue_valid & ~id_stall & issue_we & (issue_rd_s != 5'd0);
    if (do_issue) inc[issue_rd_s] = 1'b1;

    rs1_forward_id = (dec_wb[id_rs1_s] && eff[id_rs1_s] == '0) ? rs1_s_wb_id : rs1_s_id_id;
    rs2_forward_id = (dec_wb[id_rs2_s] && eff[id_rs2_s] == '0) ? rs2_s_wb_id : rs2_s_id_id;

    // Underflow clamps at zero, overflow saturates; both are sticky errors.
    for (int r = 1; r < 32; r++) begin
      c_ext = (CNT_W+2)'(cnt_q[r]);
      n_ext = (CNT_W+2)'(dec_wb[r]) + (CNT_W+2)'(dec_sq[r]);
      tot   = c_ext + (CNT_W+2)'(inc[r]) - n_ext;
      if (c_ext < n_ext) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else if (tot > (CNT_W+2)'(CNT_MAX)) begin
        cnt_d[r] = CNT_MAX;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = tot[CNT_W-1:0];
      end
      inflight_d = inflight_d + 6'(cnt_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is control state, not storage, so every entry is reset.
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign inflight = inflight_q;
  assign sb_err   = sb_err_q;

endmodule
